coeff_flux_sched: RTL and testbench
===================================

COEFF_FLUX_SCHED -- requirements
Module: coeff_flux_sched

Interface
REQ-001 Parameter FLUX, default 2: number of tagged data fluxes sharing the luma coefficient generator.
REQ-002 Parameter BURST, default 8: tokens per row burst served atomically to one flux.
REQ-003 Parameter STALL_LIMIT, default 4: consecutive idle-stall cycles tolerated before a granted flux with zero tokens consumed is released.
REQ-004 Parameter TAG_WIDTH, default max(1,$clog2(FLUX)): tag width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 src_empty  input  FLUX  per-flux alpha FIFO empty flags.
REQ-009 dst_full  input  FLUX  per-flux OR of the eight coefficient FIFO full flags.
REQ-010 fire  input  1  actor consumed one alpha token on the granted flux this cycle.
REQ-011 grant  output  FLUX  one-hot flux enable to the actor; all-zero when idle.
REQ-012 tag  output  TAG_WIDTH  index of the granted flux.
REQ-013 busy  output  1  high while a flux is granted.
REQ-014 burst_cnt  output  $clog2(BURST+1)  tokens consumed in the current burst.
REQ-015 row_done  output  1  one-cycle pulse on burst completion.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 ready[i] SHALL equal !src_empty[i] & !dst_full[i].
REQ-018 States SHALL be IDLE and LOCK only.
REQ-019 IDLE: if any ready, select the first ready index scanning rr_ptr, rr_ptr+1, ... modulo FLUX; register grant/tag/busy; enter LOCK next cycle; burst_cnt=0.
REQ-020 IDLE with no ready: remain IDLE, grant=0, busy=0.
REQ-021 Grant latency SHALL be exactly one cycle from ready observed in IDLE to grant asserted.
REQ-022 LOCK: fire with ready[tag]=1 SHALL increment burst_cnt by 1.
REQ-023 LOCK: fire that brings burst_cnt to BURST SHALL pulse row_done next cycle, clear grant/busy/burst_cnt, set rr_ptr=(tag+1) mod FLUX, return to IDLE.
REQ-024 After row_done, at least one IDLE cycle SHALL precede the next grant (one-cycle bubble).
REQ-025 LOCK with burst_cnt>0: grant SHALL be held indefinitely regardless of stalls (row atomicity).
REQ-026 LOCK with burst_cnt=0: a stall counter SHALL count consecutive cycles with ready[tag]=0; reaching STALL_LIMIT SHALL release grant, set rr_ptr=(tag+1) mod FLUX, return to IDLE, without row_done.
REQ-027 Stall counter SHALL clear on any cycle with ready[tag]=1 and on every LOCK entry.
REQ-028 fire in IDLE, or fire with ready[tag]=0, SHALL set err=1 and SHALL NOT change burst_cnt or state.
REQ-029 err SHALL clear only on reset.
REQ-030 grant SHALL never have more than one bit set; tag SHALL equal the index of the set bit when busy=1, else hold 0.
REQ-031 FLUX=1 SHALL degenerate to a single flux with rr_ptr fixed at 0.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, grant=0, tag=0, busy=0, burst_cnt=0, row_done=0, err=0, rr_ptr=0, stall counter=0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst without row_done; after release, arbitration restarts from flux 0.

Verification (FLUX=2, BURST=4, STALL_LIMIT=3)
REQ-035 Both fluxes ready from reset, fire every LOCK cycle -> grant 01 for 4 fires, row_done, one-cycle bubble, grant 10 for 4 fires, then 01 again.
REQ-036 Flux 0 only ready -> consecutive flux-0 bursts separated by one IDLE cycle; grant never 10.
REQ-037 Flux 0 granted, src_empty[0]=1 for 3 cycles before any fire, flux 1 ready -> grant released without row_done; flux 1 granted next.
REQ-038 Flux 0 granted, 2 fires, then dst_full[0]=1 for 10 cycles -> grant stays 01, burst_cnt=2; completes after full clears.
REQ-039 fire pulsed while IDLE -> err=1 sticky, state and burst_cnt unchanged.
REQ-040 rst_n pulsed low at burst_cnt=3 -> all outputs zero immediately; after release both ready -> flux 0 granted first.

Source files
------------

// File: rtl/coeff_flux_sched.sv
// rtl/coeff_flux_sched.sv - round-robin burst scheduler sharing one coefficient generator across fluxes
module coeff_flux_sched #(
    parameter int FLUX        = 2,
    parameter int BURST       = 8,
    parameter int STALL_LIMIT = 4,
    parameter int TAG_WIDTH   = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLUX-1:0]            src_empty,
    input  logic [FLUX-1:0]            dst_full,
    input  logic                       fire,
    output logic [FLUX-1:0]            grant,
    output logic [TAG_WIDTH-1:0]       tag,
    output logic                       busy,
    output logic [$clog2(BURST+1)-1:0] burst_cnt,
    output logic                       row_done,
    output logic                       err
);
    localparam int CW = $clog2(BURST+1);
    localparam int SW = $clog2(STALL_LIMIT+1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state, state_nxt;
    logic [TAG_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [SW-1:0]        stall_cnt, stall_nxt;
    logic [FLUX-1:0]      grant_nxt;
    logic [TAG_WIDTH-1:0] tag_nxt;
    logic                 busy_nxt;
    logic [CW-1:0]        burst_nxt;
    logic                 row_done_nxt;
    logic                 err_nxt;

    logic [FLUX-1:0] ready;
    logic            tag_ready;
    logic            fire_ok;
    logic            found;
    logic            release_lock;
    int              pick_idx;
    int              scan_idx;
    int              wrap_idx;

    assign ready     = ~src_empty & ~dst_full;
    assign tag_ready = ready[tag];
    assign fire_ok   = fire & tag_ready;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        stall_nxt    = stall_cnt;
        grant_nxt    = grant;
        tag_nxt      = tag;
        busy_nxt     = busy;
        burst_nxt    = burst_cnt;
        row_done_nxt = 1'b0;
        err_nxt      = err;
        release_lock = 1'b0;
        found        = 1'b0;
        pick_idx     = 0;
        scan_idx     = 0;
        wrap_idx     = (int'(tag) + 1) % FLUX;

        // first ready flux at or after rr_ptr, wrapping
        for (int k = 0; k < FLUX; k++) begin
            scan_idx = (int'(rr_ptr) + k) % FLUX;
            if (!found && ready[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end

        case (state)
            IDLE: begin
                if (fire) err_nxt = 1'b1;
                if (found) begin
                    state_nxt = LOCK;
                    grant_nxt = FLUX'(1) << pick_idx;
                    tag_nxt   = TAG_WIDTH'(pick_idx);
                    busy_nxt  = 1'b1;
                    burst_nxt = '0;
                    stall_nxt = '0;
                end
            end
            LOCK: begin
                if (fire && !tag_ready) err_nxt = 1'b1;
                if (fire_ok) begin
                    stall_nxt = '0;
                    if (burst_cnt == CW'(BURST - 1)) begin
                        release_lock = 1'b1;
                        row_done_nxt = 1'b1;
                    end else begin
                        burst_nxt = burst_cnt + 1'b1;
                    end
                end else if (tag_ready) begin
                    stall_nxt = '0;
                end else if (burst_cnt == '0) begin
                    // an empty burst may be abandoned; a started row never is
                    if (stall_cnt == SW'(STALL_LIMIT - 1)) release_lock = 1'b1;
                    else stall_nxt = stall_cnt + 1'b1;
                end
                if (release_lock) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    tag_nxt    = '0;
                    busy_nxt   = 1'b0;
                    burst_nxt  = '0;
                    stall_nxt  = '0;
                    rr_ptr_nxt = TAG_WIDTH'(wrap_idx);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            grant     <= '0;
            tag       <= '0;
            busy      <= 1'b0;
            burst_cnt <= '0;
            row_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            stall_cnt <= stall_nxt;
            grant     <= grant_nxt;
            tag       <= tag_nxt;
            busy      <= busy_nxt;
            burst_cnt <= burst_nxt;
            row_done  <= row_done_nxt;
            err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_coeff_flux_sched.sv
// tb/tb_coeff_flux_sched.sv - directed self-checking bench for coeff_flux_sched
module tb_coeff_flux_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] src_empty = 2'b11;
    logic [1:0] dst_full = 2'b00;
    logic       fire = 1'b0;
    logic [1:0] grant;
    logic       tag;
    logic       busy;
    logic [2:0] burst_cnt;
    logic       row_done;
    logic       err;

    int tests = 0;
    int fails = 0;

    coeff_flux_sched #(.FLUX(2), .BURST(4), .STALL_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .src_empty(src_empty), .dst_full(dst_full),
        .fire(fire), .grant(grant), .tag(tag), .busy(busy),
        .burst_cnt(burst_cnt), .row_done(row_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fire  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // grant already up; fire BURST times, expect row_done then a bubble
    task automatic run_burst(input string name, input logic [1:0] g);
        check({name, "_grant"}, grant, g);
        check({name, "_tag"}, tag, g[1]);
        fire = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check({name, "_cnt"}, burst_cnt, i);
        end
        step();
        fire = 1'b0;
        check({name, "_row_done"}, row_done, 1);
        check({name, "_bubble_grant"}, grant, 0);
        check({name, "_bubble_busy"}, busy, 0);
        step();
        check({name, "_row_done_pulse"}, row_done, 0);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        step();
        rst_n = 1'b1;

        // both fluxes ready: alternate bursts
        src_empty = 2'b00;
        step();
        check("first_busy", busy, 1);
        check("first_cnt", burst_cnt, 0);
        run_burst("rr_f0", 2'b01);
        run_burst("rr_f1", 2'b10);
        check("rr_back_f0", grant, 2'b01);

        // flux 0 only
        do_reset();
        src_empty = 2'b10;
        step();
        run_burst("solo_a", 2'b01);
        run_burst("solo_b", 2'b01);
        check("solo_c", grant, 2'b01);

        // zero-token stall release
        do_reset();
        src_empty = 2'b00;
        step();
        check("stall_grant0", grant, 2'b01);
        src_empty = 2'b01;
        step();
        check("stall_hold1", grant, 2'b01);
        step();
        check("stall_hold2", grant, 2'b01);
        step();
        check("stall_release", grant, 0);
        check("stall_no_row_done", row_done, 0);
        step();
        check("stall_next_f1", grant, 2'b10);
        check("stall_next_tag", tag, 1);

        // started row held through long stall
        do_reset();
        src_empty = 2'b00;
        step();
        fire = 1'b1;
        step();
        step();
        fire = 1'b0;
        check("atom_cnt2", burst_cnt, 2);
        dst_full = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step();
            check("atom_hold_grant", grant, 2'b01);
            check("atom_hold_cnt", burst_cnt, 2);
        end
        dst_full = 2'b00;
        fire = 1'b1;
        step();
        check("atom_cnt3", burst_cnt, 3);
        step();
        fire = 1'b0;
        check("atom_row_done", row_done, 1);
        check("atom_err_clean", err, 0);

        // fire while idle
        do_reset();
        src_empty = 2'b11;
        fire = 1'b1;
        step();
        fire = 1'b0;
        check("idle_fire_err", err, 1);
        check("idle_fire_busy", busy, 0);
        check("idle_fire_cnt", burst_cnt, 0);
        step();
        step();
        check("idle_err_sticky", err, 1);

        // fire on a non-ready granted flux
        do_reset();
        src_empty = 2'b00;
        step();
        fire = 1'b1;
        step();
        dst_full = 2'b01;
        step();
        fire = 1'b0;
        check("lock_bad_fire_err", err, 1);
        check("lock_bad_fire_cnt", burst_cnt, 1);
        check("lock_bad_fire_grant", grant, 2'b01);
        dst_full = 2'b00;

        // async reset mid-burst
        do_reset();
        src_empty = 2'b00;
        step();
        fire = 1'b1;
        step();
        step();
        step();
        fire = 1'b0;
        check("mid_cnt3", burst_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", grant, 0);
        check("async_busy", busy, 0);
        check("async_cnt", burst_cnt, 0);
        check("async_row_done", row_done, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_grant", grant, 2'b01);
        check("post_rst_tag", tag, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
